// File: rtl/chain_counter.sv
// chain_counter: cascadable multi-digit modulo counter driven by an AND enable chain.
// Stage k advances when en_in is high and every lower stage sits at its terminal value.
// tc_out is combinational (en_in AND all stages terminal) so instances chain tc_out -> en_in.
// Optional macro CHAIN_COUNTER_DOWN_EN adds the up_dn input (1=up, 0=down); without it the
// counter is up-only.
module chain_counter #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en_in,
`ifdef CHAIN_COUNTER_DOWN_EN
  input  logic                      up_dn,
`endif
  input  logic                      clr,
  input  logic                      load,
  input  logic [STAGES*WIDTH-1:0]   load_val,
  output logic [STAGES*WIDTH-1:0]   count,
  output logic                      tc_out,
  output logic                      load_err
);

  localparam int unsigned   TOTAL_W   = STAGES * WIDTH;
  localparam logic [WIDTH-1:0] MAX_DIGIT = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2**WIDTH is representable for the saturation compare.
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULO);

  logic                 up;
  logic [STAGES:0]      chain;
  logic [TOTAL_W-1:0]   next_count;
  logic [TOTAL_W-1:0]   load_next;
  logic                 load_sat;
  logic [WIDTH-1:0]     digit;
  logic [WIDTH-1:0]     ld_digit;
  logic                 term;

`ifdef CHAIN_COUNTER_DOWN_EN
  assign up = up_dn;
`else
  assign up = 1'b1;
`endif

  // Enable chain, per-stage increment/decrement with wrap, and saturated load value.
  always_comb begin
    chain      = '0;
    chain[0]   = en_in;
    next_count = count;
    load_next  = '0;
    load_sat   = 1'b0;
    digit      = '0;
    ld_digit   = '0;
    term       = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      digit        = count[k*WIDTH +: WIDTH];
      term         = up ? (digit == MAX_DIGIT) : (digit == '0);
      chain[k+1]   = chain[k] & term;
      if (chain[k]) begin
        if (term) begin
          next_count[k*WIDTH +: WIDTH] = up ? '0 : MAX_DIGIT;
        end else begin
          next_count[k*WIDTH +: WIDTH] = up ? (digit + WIDTH'(1)) : (digit - WIDTH'(1));
        end
      end
      ld_digit = load_val[k*WIDTH +: WIDTH];
      if ({1'b0, ld_digit} >= MOD_EXT) begin
        load_next[k*WIDTH +: WIDTH] = MAX_DIGIT;
        load_sat                    = 1'b1;
      end else begin
        load_next[k*WIDTH +: WIDTH] = ld_digit;
      end
    end
  end

  assign tc_out = chain[STAGES];

  // Count register and load-error flag; clr beats load beats count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      load_err <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= load_next;
      load_err <= load_sat;
    end else begin
      count    <= next_count;
    end
  end

endmodule

// File: tb/tb_chain_counter.sv
// Bench for chain_counter (STAGES=2, WIDTH=4, MODULO=10) with a second chained instance.
module tb_chain_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en_in = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count;
  logic       tc_out;
  logic       load_err;
  logic [7:0] hi_count;
  logic       hi_tc;
  logic       hi_err;
  logic       hi_load = 1'b0;
  logic [7:0] hi_val = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chain_counter #(.STAGES(2), .WIDTH(4), .MODULO(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_in    (en_in),
`ifdef CHAIN_COUNTER_DOWN_EN
    .up_dn    (up_dn),
`endif
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc_out   (tc_out),
    .load_err (load_err)
  );

  chain_counter #(.STAGES(2), .WIDTH(4), .MODULO(10)) dut_hi (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_in    (tc_out),
`ifdef CHAIN_COUNTER_DOWN_EN
    .up_dn    (up_dn),
`endif
    .clr      (clr),
    .load     (hi_load),
    .load_val (hi_val),
    .count    (hi_count),
    .tc_out   (hi_tc),
    .load_err (hi_err)
  );

  // Decimal value 0..99 to the two-digit packed count image.
  function automatic logic [7:0] enc(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int clip(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL reset_count got=%h exp=00", count); end
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", load_err); end
    n_cmp++; if (tc_out !== 1'b0) begin n_err++; $display("FAIL reset_tc got=%b exp=0", tc_out); end
    step();
    reset_n = 1'b1;
    step();
    load = 1'b1; load_val = 8'h36;
    step();
    load = 1'b0; en_in = 1'b1;
    step();
    n_cmp++; if (count !== 8'h37) begin n_err++; $display("FAIL pre_reset_count got=%h exp=37", count); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL midcount_reset_count got=%h exp=00", count); end
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL midcount_reset_err got=%b exp=0", load_err); end
    n_cmp++; if (tc_out !== 1'b0) begin n_err++; $display("FAIL midcount_reset_tc got=%b exp=0", tc_out); end
    en_in = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    load = 1'b1; load_val = 8'h98;
    step();
    load = 1'b0;
    n_cmp++; if (count !== 8'h98) begin n_err++; $display("FAIL wrap_load got=%h exp=98", count); end
    en_in = 1'b1;
    #1;
    n_cmp++; if (tc_out !== 1'b0) begin n_err++; $display("FAIL wrap_tc_98 got=%b exp=0", tc_out); end
    step();
    n_cmp++; if (count !== 8'h99) begin n_err++; $display("FAIL wrap_99 got=%h exp=99", count); end
    n_cmp++; if (tc_out !== 1'b1) begin n_err++; $display("FAIL wrap_tc_99 got=%b exp=1", tc_out); end
    step();
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL wrap_00 got=%h exp=00", count); end
    n_cmp++; if (tc_out !== 1'b0) begin n_err++; $display("FAIL wrap_tc_00 got=%b exp=0", tc_out); end
    en_in = 1'b0;
    #1;
    n_cmp++; if (tc_out !== 1'b0) begin n_err++; $display("FAIL hold_tc got=%b exp=0", tc_out); end
  endtask

  task automatic test_load_sat();
    load = 1'b1; load_val = 8'hF3;
    step();
    n_cmp++; if (count !== 8'h93) begin n_err++; $display("FAIL sat_count got=%h exp=93", count); end
    n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL sat_err got=%b exp=1", load_err); end
    load_val = 8'h12;
    step();
    load = 1'b0;
    n_cmp++; if (count !== 8'h12) begin n_err++; $display("FAIL ok_count got=%h exp=12", count); end
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL ok_err got=%b exp=0", load_err); end
    load = 1'b1; load_val = 8'h4C;
    step();
    load = 1'b0;
    n_cmp++; if (count !== 8'h49) begin n_err++; $display("FAIL sat_lo_count got=%h exp=49", count); end
    n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL sat_lo_err got=%b exp=1", load_err); end
    step();
    n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL err_hold got=%b exp=1", load_err); end
  endtask

  task automatic test_priority();
    load = 1'b1; load_val = 8'hAA;
    step();
    clr = 1'b1; load = 1'b1; en_in = 1'b1; load_val = 8'h55;
    step();
    clr = 1'b0; load = 1'b0; en_in = 1'b0;
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL prio_count got=%h exp=00", count); end
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL prio_err got=%b exp=0", load_err); end
    load = 1'b1; en_in = 1'b1; load_val = 8'h27;
    step();
    load = 1'b0; en_in = 1'b0;
    n_cmp++; if (count !== 8'h27) begin n_err++; $display("FAIL load_over_en got=%h exp=27", count); end
  endtask

  task automatic test_random();
    int v;
    bit e;
    logic exp_tc;
    clr = 1'b1;
    step();
    clr = 1'b0;
    v = 0;
    e = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int r;
      en_in    = ($urandom_range(0, 3) != 0);
      r        = $urandom_range(0, 19);
      clr      = (r == 0);
      load     = (r == 1 || r == 2);
      load_val = 8'($urandom);
      #1;
      exp_tc = en_in && (v == 99);
      n_cmp++; if (tc_out !== exp_tc) begin n_err++; $display("FAIL rnd_tc i=%0d got=%b exp=%b", i, tc_out, exp_tc); end
      step();
      if (clr) begin
        v = 0; e = 1'b0;
      end else if (load) begin
        v = 10 * clip(int'(load_val[7:4])) + clip(int'(load_val[3:0]));
        e = (load_val[7:4] > 4'd9) || (load_val[3:0] > 4'd9);
      end else if (en_in) begin
        v = (v + 1) % 100;
      end
      n_cmp++; if (count !== enc(v)) begin n_err++; $display("FAIL rnd_count i=%0d got=%h exp=%h", i, count, enc(v)); end
      n_cmp++; if (load_err !== e) begin n_err++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, load_err, e); end
    end
    clr = 1'b0; load = 1'b0; en_in = 1'b0;
  endtask

  task automatic test_chain();
    int pulses;
    pulses = 0;
    en_in = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    en_in = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (hi_tc === 1'b1) pulses++;
      n_cmp++;
      if (count !== enc(i % 100) || hi_count !== enc((i / 100) % 100)) begin
        n_err++;
        $display("FAIL chain_count i=%0d got=%h_%h exp=%h_%h", i, hi_count, count,
                 enc((i / 100) % 100), enc(i % 100));
      end
    end
    @(negedge clk);
    en_in = 1'b0;
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL chain_lo_end got=%h exp=00", count); end
    n_cmp++; if (hi_count !== 8'h00) begin n_err++; $display("FAIL chain_hi_end got=%h exp=00", hi_count); end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL chain_pulses got=%0d exp=1", pulses); end
    step();
  endtask

`ifdef CHAIN_COUNTER_DOWN_EN
  task automatic test_down();
    clr = 1'b1;
    step();
    clr = 1'b0;
    up_dn = 1'b0;
    en_in = 1'b1;
    #1;
    n_cmp++; if (tc_out !== 1'b1) begin n_err++; $display("FAIL down_tc got=%b exp=1", tc_out); end
    step();
    n_cmp++; if (count !== 8'h99) begin n_err++; $display("FAIL down_wrap got=%h exp=99", count); end
    step();
    n_cmp++; if (count !== 8'h98) begin n_err++; $display("FAIL down_dec got=%h exp=98", count); end
    en_in = 1'b0;
    up_dn = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_load_sat();
    test_priority();
    test_random();
    test_chain();
`ifdef CHAIN_COUNTER_DOWN_EN
    test_down();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
